joybus_line_ctrl: RTL and testbench
===================================

Name: joybus_line_ctrl

Overview:
Host-side transaction sequencer for the single shared N64 joybus data line. Drives the open-drain line to send one 8-bit command plus stop bit, then turns the line around and decodes the controller's reply from the glitch-filtered line input. Sits between the console-side command logic and the line pad/filter pair, and owns all direction switching and timing on that line.

Parameters:
CLK_PER_US, 50, sys_clk cycles per microsecond; all bit timing derives from it.
TIMEOUT_US, 64, maximum line-idle time in RX before the transaction aborts.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle request; sampled only in IDLE
tx_cmd  in  8  command byte, latched on accepted start
rx_len  in  3  reply length in bytes, 0..4; latched on accepted start; values 5..7 treated as 4
line_in  in  1  filtered line level; 1 = released/high
line_oe  out  1  1 = pull line low; 0 = release
busy  out  1  high from the cycle after an accepted start until done or timeout pulses
done  out  1  one-cycle pulse, transaction completed
timeout  out  1  one-cycle pulse, transaction aborted
rx_data  out  32  reply bits, MSB-first shift; valid when done pulses

Behaviour:
- Reset: line_oe=0, busy=0, done=0, timeout=0, rx_data=0, state IDLE. Assertion mid-transaction releases the line immediately (asynchronous).
- States: IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_LOW, RX_STOP, FINISH.
- IDLE: on start, latch tx_cmd/rx_len, clear rx_data, set bit index 7 -> TX_LOW. start while not IDLE is ignored.
- TX bit (MSB first, 4 us per bit): TX_LOW drives line_oe=1 for 1 us (bit=1) or 3 us (bit=0); TX_HIGH releases for the remaining 3 us or 1 us. After bit 0 -> TX_STOP.
- TX_STOP: line_oe=1 for 1 us, then release. If rx_len=0 -> FINISH, else -> RX_WAIT with the timeout counter cleared.
- Edge detection uses a one-cycle registered copy of line_in; line_in is already synchronous, so no extra synchroniser.
- RX_WAIT: a falling edge -> RX_LOW with the width counter cleared. TIMEOUT_US*CLK_PER_US cycles without a falling edge -> timeout pulse, busy=0, IDLE.
- RX_LOW: count cycles while line_in=0. On the rising edge, width < 2*CLK_PER_US shifts in 1, otherwise 0 (rx_data <= {rx_data[30:0], bit}). After rx_len*8 bits -> RX_STOP, else -> RX_WAIT.
- Low longer than TIMEOUT_US in RX_LOW (line stuck low) -> timeout.
- RX_STOP: wait for the controller stop bit (falling then rising edge); width is not checked. The TIMEOUT_US rule applies to both edges. On the rising edge -> FINISH.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Short replies (rx_len<4) are right-justified in rx_data, with the upper bits zero.
- line_oe is never 1 in any RX state. Transmit timing is exact to the cycle, counters are sized from parameters, and the filter's input-to-output delay is ignored because it is symmetric on both edges.

Test Plan:
- Reset check: pulse sys_rst_n low with no clock running -> line_oe=0, busy=0, rx_data=0.
- TX framing, CLK_PER_US=50: start with tx_cmd=0x01, rx_len=0 -> seven line_oe lows of 150 cycles, each followed by 50 high; then a 50-cycle low and 150 high; then a 50-cycle stop low. done pulses next, total frame 1650 cycles.
- RX decode: tx_cmd=0x00, rx_len=3; bench model answers 0x050002 (1 us low = 1, 3 us low = 0) plus a 2 us stop -> done pulses with rx_data=0x00050002 and no timeout.
- Silent device: rx_len=4, line never driven after stop -> timeout pulses exactly 3200 cycles after the stop-bit release; done never asserts; busy drops.
- Start while busy: second start with tx_cmd=0xFF mid-frame -> ignored, original 0x01 frame completes unchanged.
- Reset mid-RX: assert sys_rst_n after 10 received bits -> line_oe=0, rx_data=0; a fresh transaction afterwards succeeds.

Source files
------------

// File: rtl/joybus_line_ctrl.sv
// Host-side N64 joybus sequencer: sends one command byte plus stop bit on the
// open-drain line, then decodes the controller reply by pulse width.
module joybus_line_ctrl #(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned TIMEOUT_US = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [7:0]  tx_cmd,
  input  logic [2:0]  rx_len,
  input  logic        line_in,
  output logic        line_oe,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rx_data
);

  localparam int unsigned TO_CYC = TIMEOUT_US * CLK_PER_US;
  localparam int unsigned MAXC   = (TO_CYC > 3 * CLK_PER_US) ? TO_CYC : 3 * CLK_PER_US;
  localparam int unsigned CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] C_1US = CW'(CLK_PER_US - 1);
  localparam logic [CW-1:0] C_2US = CW'(2 * CLK_PER_US - 1);
  localparam logic [CW-1:0] C_3US = CW'(3 * CLK_PER_US - 1);
  localparam logic [CW-1:0] C_TO  = CW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_LOW, RX_STOP, FINISH
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_cmd;
  logic [2:0]    r_bit_idx;
  logic [2:0]    r_len;
  logic [5:0]    r_rx_cnt;
  logic [31:0]   r_rx_data;
  logic          r_line_d;
  logic          r_stop_low;
  logic          r_timeout;

  logic w_fall, w_rise, w_tx_bit, w_rx_bit, w_last_bit;
  logic w_accept, w_bit_adv, w_shift, w_to, w_cnt_clr, w_stop_fall;

  assign w_fall     = r_line_d & ~line_in;
  assign w_rise     = ~r_line_d & line_in;
  assign w_tx_bit   = r_cmd[r_bit_idx];
  // r_cnt + 1 is the number of low cycles seen when the rising edge arrives
  assign w_rx_bit   = (r_cnt < C_2US);
  assign w_last_bit = ((r_rx_cnt + 6'd1) == {r_len, 3'b000});

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_bit_adv   = 1'b0;
    w_shift     = 1'b0;
    w_to        = 1'b0;
    w_stop_fall = 1'b0;
    unique case (r_state)
      IDLE: if (start) begin
        w_accept = 1'b1;
        w_next   = TX_LOW;
      end
      TX_LOW:  if (r_cnt == (w_tx_bit ? C_1US : C_3US)) w_next = TX_HIGH;
      TX_HIGH: if (r_cnt == (w_tx_bit ? C_3US : C_1US)) begin
        w_bit_adv = 1'b1;
        w_next    = (r_bit_idx == 3'd0) ? TX_STOP : TX_LOW;
      end
      TX_STOP: if (r_cnt == C_1US) w_next = (r_len == 3'd0) ? FINISH : RX_WAIT;
      RX_WAIT: begin
        if (w_fall) w_next = RX_LOW;
        else if (r_cnt == C_TO) begin
          w_to   = 1'b1;
          w_next = IDLE;
        end
      end
      RX_LOW: begin
        if (w_rise) begin
          w_shift = 1'b1;
          w_next  = w_last_bit ? RX_STOP : RX_WAIT;
        end else if (r_cnt == C_TO) begin
          w_to   = 1'b1;
          w_next = IDLE;
        end
      end
      RX_STOP: begin
        // The stop bit's falling edge restarts the idle timer for the rising edge
        if (!r_stop_low && w_fall) w_stop_fall = 1'b1;
        else if (r_stop_low && w_rise) w_next = FINISH;
        else if (r_cnt == C_TO) begin
          w_to   = 1'b1;
          w_next = IDLE;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_cnt_clr = (w_next != r_state) | w_stop_fall | (r_state == IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt      <= '0;
      r_cmd      <= '0;
      r_bit_idx  <= '0;
      r_len      <= '0;
      r_rx_cnt   <= '0;
      r_rx_data  <= '0;
      r_line_d   <= 1'b1;
      r_stop_low <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_line_d  <= line_in;
      r_timeout <= w_to;
      r_cnt     <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (w_accept) begin
        r_cmd     <= tx_cmd;
        r_len     <= (rx_len > 3'd4) ? 3'd4 : rx_len;
        r_bit_idx <= 3'd7;
        r_rx_cnt  <= '0;
        r_rx_data <= '0;
      end
      if (w_bit_adv) r_bit_idx <= r_bit_idx - 3'd1;
      if (w_shift) begin
        r_rx_data <= {r_rx_data[30:0], w_rx_bit};
        r_rx_cnt  <= r_rx_cnt + 6'd1;
      end
      if (r_state != RX_STOP) r_stop_low <= 1'b0;
      else if (w_stop_fall)   r_stop_low <= 1'b1;
    end
  end

  assign line_oe = (r_state == TX_LOW) || (r_state == TX_STOP);
  assign busy    = (r_state != IDLE) && (r_state != FINISH);
  assign done    = (r_state == FINISH);
  assign timeout = r_timeout;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_joybus_line_ctrl.sv
// Scoreboard bench for joybus_line_ctrl: a controller model answers on the line,
// expected pulses and transaction endings are queued and checked by a monitor.
module tb_joybus_line_ctrl;
  localparam int CPU = 50;
  localparam int TUS = 64;

  logic        clk = 1'b0;
  logic        rst_n, start, line_in, line_oe, busy, done, timeout, dev_low;
  logic [7:0]  tx_cmd;
  logic [2:0]  rx_len;
  logic [31:0] rx_data;

  int checks = 0, errors = 0;
  int cyc = 0, oe_falls = 0, frame_base = 0;
  bit clk_run = 1'b0;

  typedef struct { int rel; int width; } pulse_t;
  typedef struct { bit is_to; logic [31:0] data; int lat; } end_t;
  pulse_t pq[$];
  end_t   eq[$];

  assign line_in = ~(line_oe | dev_low);

  joybus_line_ctrl #(.CLK_PER_US(CPU), .TIMEOUT_US(TUS)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .tx_cmd(tx_cmd),
    .rx_len(rx_len), .line_in(line_in), .line_oe(line_oe), .busy(busy),
    .done(done), .timeout(timeout), .rx_data(rx_data)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic prev_oe = 1'b0;
    int   rise_cyc = 0;
    pulse_t p;
    end_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_oe = 1'b0;
      else begin
        if (line_oe && !prev_oe) begin
          rise_cyc = cyc;
          if (pq.size() == 0) chk("oe_unexpected", {31'd0, line_oe}, 32'd0);
          else if (pq[0].rel == 0) frame_base = cyc;
        end
        if (!line_oe && prev_oe) begin
          oe_falls++;
          if (pq.size() > 0) begin
            p = pq.pop_front();
            chk("oe_start", rise_cyc - frame_base, p.rel);
            chk("oe_width", cyc - rise_cyc, p.width);
          end
        end
        prev_oe = line_oe;
        if (done || timeout) begin
          if (eq.size() == 0) chk("end_unexpected", {30'd0, done, timeout}, 32'd0);
          else begin
            e = eq.pop_front();
            chk("end_kind", {30'd0, done, timeout}, e.is_to ? 32'd1 : 32'd2);
            chk("end_busy", {31'd0, busy}, 32'd0);
            if (!e.is_to) chk("rx_data", rx_data, e.data);
            if (e.lat >= 0) chk("end_latency", cyc - frame_base, e.lat);
          end
        end
      end
    end
  endtask

  // Controller-side bit: 1 us low = 1, 3 us low = 0, with jitter, 4 us period
  task automatic dev_bit(input bit b);
    int lo;
    lo = b ? $urandom_range(35, 65) : $urandom_range(135, 165);
    dev_low = 1'b1;
    repeat (lo) @(posedge clk);
    #1 dev_low = 1'b0;
    repeat (4 * CPU - lo) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) dev_bit(v[i]);
  endtask

  task automatic issue_start(input logic [7:0] cmd, input logic [2:0] len);
    @(posedge clk);
    #1 start = 1'b1; tx_cmd = cmd; rx_len = len;
    @(posedge clk);
    #1 start = 1'b0; tx_cmd = 8'($urandom); rx_len = 3'($urandom);
  endtask

  task automatic wait_tx_frame(input int target);
    int c = 0;
    while (oe_falls < target && c < 2500) begin
      @(posedge clk);
      c++;
    end
    if (oe_falls < target) chk("tx_frame_seen", oe_falls, target);
    #1;
  endtask

  // mode 0: controller replies, 1: silent, 2: line stuck low
  task automatic run_txn(input logic [7:0] cmd, input int len, input logic [31:0] reply,
                         input int mode, input bit inject);
    int eff, target, c;
    end_t e;
    eff = (len > 4) ? 4 : len;
    for (int i = 7; i >= 0; i--) pq.push_back('{(7 - i) * 4 * CPU, cmd[i] ? CPU : 3 * CPU});
    pq.push_back('{32 * CPU, CPU});
    e.data = (eff == 4) ? reply : (reply & ((32'd1 << (eff * 8)) - 32'd1));
    e.is_to = (eff != 0) && (mode != 0);
    if (eff == 0) e.lat = 33 * CPU;
    else if (mode == 1) e.lat = 33 * CPU + TUS * CPU;
    else e.lat = -1;
    eq.push_back(e);
    target = oe_falls + 9;
    issue_start(cmd, 3'(len));
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    if (inject) begin
      repeat (500) @(posedge clk);
      #1 start = 1'b1; tx_cmd = 8'hFF; rx_len = 3'd3;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_tx_frame(target);
    if (eff > 0 && mode == 0) begin
      repeat ($urandom_range(5, 400)) @(posedge clk);
      #1;
      send_bits(e.data, eff * 8);
      dev_low = 1'b1;
      repeat (2 * CPU) @(posedge clk);
      #1 dev_low = 1'b0;
    end else if (eff > 0 && mode == 2) begin
      repeat (20) @(posedge clk);
      #1 dev_low = 1'b1;
      repeat (TUS * CPU + 100) @(posedge clk);
      #1 dev_low = 1'b0;
    end
    c = 0;
    while (eq.size() != 0 && c < 6000) begin
      @(posedge clk);
      c++;
    end
    if (eq.size() != 0) begin
      chk("txn_end_seen", eq.size(), 0);
      eq.delete();
    end
    repeat (20) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; tx_cmd = '0; rx_len = '0; dev_low = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_line_oe", {31'd0, line_oe}, 32'd0);
    chk("reset_busy",    {31'd0, busy}, 32'd0);
    chk("reset_done",    {31'd0, done}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    chk("reset_rx_data", rx_data, 32'd0);
    clk_run = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    run_txn(8'h01, 0, 32'd0, 0, 1'b0);
    run_txn(8'h01, 0, 32'd0, 0, 1'b1);
    run_txn(8'h00, 3, 32'h0005_0002, 0, 1'b0);
    run_txn(8'h00, 4, 32'd0, 1, 1'b0);
    run_txn(8'hC7, 1, 32'd0, 2, 1'b0);
    run_txn(8'h80, 6, $urandom, 0, 1'b0);
    for (int n = 0; n < 4; n++)
      run_txn(8'($urandom), $urandom_range(0, 7), $urandom, 0, $urandom_range(0, 3) == 0);

    // Reset in the middle of a reply, then a clean transaction
    for (int i = 7; i >= 0; i--) pq.push_back('{(7 - i) * 4 * CPU, 3 * CPU});
    pq.push_back('{32 * CPU, CPU});
    eq.push_back('{1'b0, 32'd0, -1});
    issue_start(8'h00, 3'd4);
    wait_tx_frame(oe_falls + 9);
    repeat (30) @(posedge clk);
    #1 send_bits(32'h297, 10);
    @(posedge clk);
    #3 rst_n = 1'b0; dev_low = 1'b0;
    #1;
    chk("midrx_line_oe", {31'd0, line_oe}, 32'd0);
    chk("midrx_rx_data", rx_data, 32'd0);
    chk("midrx_busy",    {31'd0, busy}, 32'd0);
    eq.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run_txn(8'h5A, 2, $urandom, 0, 1'b0);

    chk("pulse_queue_empty", pq.size(), 0);
    chk("end_queue_empty", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
